// File: rtl/taxi_episode_ctrl.sv
// taxi_episode_ctrl: episode sequencer between the agent handshake and the Taxi step core
module taxi_episode_ctrl #(
    parameter int STEP_LAT  = 1,
    parameter int MAX_STEPS = 200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [8:0]  i_init_state,
    input  logic        i_act_valid,
    input  logic [2:0]  i_act,
    output logic        o_act_ready,
    output logic [8:0]  o_step_state,
    output logic [2:0]  o_step_action,
    input  logic [8:0]  i_step_next_state,
    input  logic [1:0]  i_step_reward,
    input  logic        i_step_terminated,
    output logic        o_obs_valid,
    output logic [8:0]  o_obs_state,
    output logic [1:0]  o_obs_reward,
    output logic        o_obs_terminated,
    output logic        o_obs_truncated,
    output logic        o_obs_illegal,
    output logic [15:0] o_ep_return,
    output logic [7:0]  o_step_count,
    output logic        o_episode_done
);
    typedef enum logic [2:0] {IDLE, READY, WAIT, UPDATE, DONE} state_t;
    localparam int LW = $clog2(STEP_LAT + 1);

    state_t      r_state, w_next;
    logic [LW-1:0] r_lat;
    logic [8:0]  r_cap_state, r_obs_state;
    logic [1:0]  r_cap_reward, r_obs_reward;
    logic        r_cap_term, r_obs_valid, r_term, r_trunc, r_ill;
    logic [2:0]  r_act;
    logic [15:0] r_ret;
    logic [7:0]  r_count;
    logic        w_start, w_take, w_legal, w_lat_done, w_hit_max;
    logic [7:0]  w_cnt_nx;
    logic [16:0] w_delta, w_sum;
    logic [15:0] w_ret_nx;

    // an out-of-range start is treated as no start at all
    assign w_start    = i_start && (i_init_state <= 9'd499);
    assign w_take     = (r_state == READY) && i_act_valid && !w_start;
    assign w_legal    = i_act <= 3'd5;
    assign w_lat_done = r_lat == LW'(STEP_LAT - 1);
    assign w_cnt_nx   = r_count + 8'd1;
    assign w_hit_max  = w_cnt_nx == 8'(MAX_STEPS);
    assign w_delta    = (r_cap_reward == 2'd0) ? 17'h1FFFF :
                        (r_cap_reward == 2'd1) ? 17'h1FFF6 :
                        (r_cap_reward == 2'd2) ? 17'd20 : 17'd0;
    assign w_sum      = {r_ret[15], r_ret} + w_delta;
    assign w_ret_nx   = (w_sum[16] != w_sum[15]) ? (w_sum[16] ? 16'h8000 : 16'h7FFF) : w_sum[15:0];

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // next state: start overrides everything, illegal actions stay in READY
    always_comb begin
        w_next = w_start ? READY :
                 (w_take && w_legal) ? WAIT :
                 (r_state == WAIT && w_lat_done) ? UPDATE :
                 (r_state == UPDATE) ? ((r_cap_term || w_hit_max) ? DONE : READY) :
                 r_state;
    end

    // state-decoded outputs
    always_comb begin
        o_act_ready    = r_state == READY;
        o_episode_done = r_state == DONE;
    end

    // step latency counter and core result capture at the end of WAIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lat        <= '0;
            r_cap_state  <= '0;
            r_cap_reward <= '0;
            r_cap_term   <= 1'b0;
        end else begin
            r_lat <= (r_state == WAIT) ? r_lat + LW'(1) : '0;
            if (r_state == WAIT && w_lat_done) begin
                r_cap_state  <= i_step_next_state;
                r_cap_reward <= i_step_reward;
                r_cap_term   <= i_step_terminated;
            end
        end
    end

    // episode bookkeeping: new episode, action latch, illegal report, step commit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_obs_valid  <= 1'b0;
            r_obs_state  <= '0;
            r_obs_reward <= '0;
            r_term       <= 1'b0;
            r_trunc      <= 1'b0;
            r_ill        <= 1'b0;
            r_ret        <= '0;
            r_count      <= '0;
            r_act        <= '0;
        end else begin
            r_obs_valid <= 1'b0;
            if (w_start) begin
                r_obs_state  <= i_init_state;
                r_obs_reward <= '0;
                r_term       <= 1'b0;
                r_trunc      <= 1'b0;
                r_ill        <= 1'b0;
                r_ret        <= '0;
                r_count      <= '0;
            end else if (w_take) begin
                if (w_legal) r_act <= i_act;
                else begin
                    r_obs_valid <= 1'b1;
                    r_ill       <= 1'b1;
                end
            end else if (r_state == UPDATE) begin
                r_obs_valid  <= 1'b1;
                r_obs_state  <= r_cap_state;
                r_obs_reward <= r_cap_reward;
                r_term       <= r_cap_term;
                r_trunc      <= !r_cap_term && w_hit_max;
                r_ill        <= 1'b0;
                r_ret        <= w_ret_nx;
                r_count      <= w_cnt_nx;
            end
        end
    end

    assign o_step_state     = r_obs_state;
    assign o_step_action    = r_act;
    assign o_obs_valid      = r_obs_valid;
    assign o_obs_state      = r_obs_state;
    assign o_obs_reward     = r_obs_reward;
    assign o_obs_terminated = r_term;
    assign o_obs_truncated  = r_trunc;
    assign o_obs_illegal    = r_ill;
    assign o_ep_return      = r_ret;
    assign o_step_count     = r_count;
endmodule

// File: tb/tb_taxi_episode_ctrl.sv
// tb_taxi_episode_ctrl: scenario tasks against an episode-level reference model
module tb_taxi_episode_ctrl;
    localparam int STEP_LAT  = 1;
    localparam int MAX_STEPS = 200;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, act_valid = 1'b0, core_term = 1'b0;
    logic [8:0]  init_state = '0, core_ns = '0;
    logic [2:0]  act = '0;
    logic [1:0]  core_rw = '0;
    logic        act_ready, obs_valid, obs_term, obs_trunc, obs_ill, ep_done;
    logic [8:0]  step_state, obs_state;
    logic [2:0]  step_action;
    logic [1:0]  obs_reward;
    logic [15:0] ep_return;
    logic [7:0]  step_count;

    int n_checks = 0, n_pass = 0;

    logic [8:0] m_state;
    int         m_ret, m_cnt;
    logic [1:0] m_rw;
    logic       m_term, m_trunc, m_ill, m_done, m_ready;
    logic [2:0] m_act;

    taxi_episode_ctrl #(.STEP_LAT(STEP_LAT), .MAX_STEPS(MAX_STEPS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_init_state(init_state),
        .i_act_valid(act_valid), .i_act(act), .o_act_ready(act_ready),
        .o_step_state(step_state), .o_step_action(step_action),
        .i_step_next_state(core_ns), .i_step_reward(core_rw), .i_step_terminated(core_term),
        .o_obs_valid(obs_valid), .o_obs_state(obs_state), .o_obs_reward(obs_reward),
        .o_obs_terminated(obs_term), .o_obs_truncated(obs_trunc), .o_obs_illegal(obs_ill),
        .o_ep_return(ep_return), .o_step_count(step_count), .o_episode_done(ep_done)
    );

    always #5 clk = ~clk;

    wire [52:0] dut_v = {obs_valid, obs_state, obs_reward, obs_term, obs_trunc, obs_ill,
                         ep_return, step_count, ep_done, act_ready, step_state, step_action};

    function automatic logic [52:0] exp_vec(input logic v);
        return {v, m_state, m_rw, m_term, m_trunc, m_ill, 16'(m_ret), 8'(m_cnt),
                m_done, m_ready, m_state, m_act};
    endfunction

    function automatic int reward_value(input logic [1:0] rw);
        return (rw == 2'd0) ? -1 : (rw == 2'd1) ? -10 : (rw == 2'd2) ? 20 : 0;
    endfunction

    function automatic int clamp16(input int x);
        return (x > 32767) ? 32767 : (x < -32768) ? -32768 : x;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        m_state = '0; m_ret = 0; m_cnt = 0; m_rw = '0; m_act = '0;
        m_term = 0; m_trunc = 0; m_ill = 0; m_done = 0; m_ready = 0;
    endtask

    task automatic model_start(input logic [8:0] s);
        m_state = s; m_ret = 0; m_cnt = 0; m_rw = '0;
        m_term = 0; m_trunc = 0; m_ill = 0; m_done = 0; m_ready = 1;
    endtask

    task automatic do_start(input logic [8:0] s);
        start = 1; init_state = s;
        tick;
        start = 0;
        model_start(s);
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL start(%0d) got=%h exp=%h", s, dut_v, exp_vec(1'b0));
        else n_pass++;
    endtask

    task automatic do_step(input logic [2:0] a, input logic [8:0] ns, input logic [1:0] rw, input logic t);
        act_valid = 1; act = a; core_ns = ns; core_rw = rw; core_term = t;
        tick;
        act_valid = 0;
        m_act = a; m_ready = 0;
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL step_wait got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
        tick;
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL step_update got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
        tick;
        m_state = ns; m_rw = rw; m_ret = clamp16(m_ret + reward_value(rw)); m_cnt++;
        m_term = t; m_trunc = !t && (m_cnt == MAX_STEPS); m_ill = 0;
        m_done = t || (m_cnt == MAX_STEPS); m_ready = !m_done;
        n_checks++;
        if (dut_v !== exp_vec(1'b1)) $display("FAIL step_obs(cnt %0d) got=%h exp=%h", m_cnt, dut_v, exp_vec(1'b1));
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 0; start = 1; init_state = 9'd451; act_valid = 1; act = 3'd2;
        repeat (3) @(posedge clk);
        #1;
        model_clear;
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL reset_hold got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
        start = 0; act_valid = 0; rst_n = 1;
        for (int i = 0; i < 20; i++) begin
            act_valid = 1; act = 3'($urandom_range(0, 7));
            tick;
            n_checks++;
            if (dut_v !== exp_vec(1'b0)) $display("FAIL idle_cycle%0d got=%h exp=%h", i, dut_v, exp_vec(1'b0));
            else n_pass++;
        end
        act_valid = 0;
        start = 1; init_state = 9'(500 + $urandom_range(0, 11));
        tick;
        start = 0;
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL bad_start_idle got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
    endtask

    task automatic test_plan_steps;
        do_start(9'd451);
        do_step(3'd3, 9'd431, 2'd0, 1'b0);
        do_start(9'd431);
        do_step(3'd5, 9'd431, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            act_valid = 1; act = 3'($urandom_range(0, 5));
            tick;
            n_checks++;
            if (dut_v !== exp_vec(1'b0)) $display("FAIL done_hold%0d got=%h exp=%h", i, dut_v, exp_vec(1'b0));
            else n_pass++;
        end
        act_valid = 0;
        start = 1; init_state = 9'd510;
        tick;
        start = 0;
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL bad_start_done got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
    endtask

    task automatic test_truncation;
        do_start(9'($urandom_range(0, 499)));
        for (int i = 0; i < MAX_STEPS; i++)
            do_step(3'($urandom_range(0, 5)), 9'($urandom_range(0, 499)), 2'd0, 1'b0);
        act_valid = 1; act = 3'd1;
        tick;
        act_valid = 0;
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL trunc_hold got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
    endtask

    task automatic test_illegal;
        do_start(9'($urandom_range(0, 499)));
        do_step(3'd2, 9'($urandom_range(0, 499)), 2'd1, 1'b0);
        for (int k = 6; k < 8; k++) begin
            act_valid = 1; act = 3'(k);
            tick;
            act_valid = 0;
            m_ill = 1;
            n_checks++;
            if (dut_v !== exp_vec(1'b1)) $display("FAIL illegal%0d got=%h exp=%h", k, dut_v, exp_vec(1'b1));
            else n_pass++;
            tick;
            n_checks++;
            if (dut_v !== exp_vec(1'b0)) $display("FAIL illegal%0d_after got=%h exp=%h", k, dut_v, exp_vec(1'b0));
            else n_pass++;
        end
        do_step(3'd0, 9'($urandom_range(0, 499)), 2'd3, 1'b0);
    endtask

    task automatic test_abort;
        do_start(9'($urandom_range(0, 499)));
        act_valid = 1; act = 3'd4; core_ns = 9'd7; core_rw = 2'd2; core_term = 1;
        tick;
        act_valid = 0; m_act = 3'd4;
        start = 1; init_state = 9'd351;
        tick;
        start = 0;
        model_start(9'd351);
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL abort_wait got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
        tick;
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL abort_wait_quiet got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
        act_valid = 1; act = 3'd1; core_ns = 9'd99; core_rw = 2'd1; core_term = 0;
        tick;
        act_valid = 0; m_act = 3'd1;
        tick;
        start = 1; init_state = 9'd123;
        tick;
        start = 0;
        model_start(9'd123);
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL abort_update got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
        start = 1; init_state = 9'd200; act_valid = 1; act = 3'd3;
        tick;
        start = 0; act_valid = 0;
        model_start(9'd200);
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL start_wins got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
        tick;
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL start_wins_after got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
    endtask

    task automatic test_async_reset;
        do_start(9'($urandom_range(0, 499)));
        act_valid = 1; act = 3'd5; core_ns = 9'd42; core_rw = 2'd2; core_term = 0;
        tick;
        act_valid = 0;
        #2 rst_n = 0;
        #1;
        model_clear;
        n_checks++;
        if (dut_v !== exp_vec(1'b0)) $display("FAIL async_reset got=%h exp=%h", dut_v, exp_vec(1'b0));
        else n_pass++;
        tick;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if (dut_v !== exp_vec(1'b0)) $display("FAIL post_reset%0d got=%h exp=%h", i, dut_v, exp_vec(1'b0));
            else n_pass++;
        end
    endtask

    task automatic test_random;
        for (int ep = 0; ep < 6; ep++) begin
            do_start(9'($urandom_range(0, 499)));
            for (int k = 0; k < 40 && !m_done; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    tick;
                    n_checks++;
                    if (dut_v !== exp_vec(1'b0)) $display("FAIL rand_gap got=%h exp=%h", dut_v, exp_vec(1'b0));
                    else n_pass++;
                end else if (r < 4) begin
                    act_valid = 1; act = 3'($urandom_range(6, 7));
                    tick;
                    act_valid = 0;
                    m_ill = 1;
                    n_checks++;
                    if (dut_v !== exp_vec(1'b1)) $display("FAIL rand_illegal got=%h exp=%h", dut_v, exp_vec(1'b1));
                    else n_pass++;
                end else
                    do_step(3'($urandom_range(0, 5)), 9'($urandom_range(0, 499)),
                            2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
            end
        end
    endtask

    initial begin
        model_clear;
        test_reset;
        test_plan_steps;
        test_illegal;
        test_abort;
        test_truncation;
        test_random;
        test_async_reset;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
